// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter: iterative DES block decryptor, one Feistel round per clock over 16 rounds.
// DES_DUAL_MODE_EN adds a mode input (1 = decrypt, 0 = encrypt) that is sampled at acceptance.
module des_decrypt_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] cipher,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] plain,
    output logic        busy
`ifdef DES_DUAL_MODE_EN
    ,
    input  logic        mode
`endif
);
    localparam int ip_t [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
    localparam int fp_t [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
    localparam int e_t [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                                16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    localparam int p_t [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
    localparam int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                  41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    // S1..S8 back to back, each 64 entries indexed by {b1,b6,b2..b5}
    localparam logic [3:0] sbox [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-ip_t[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-fp_t[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-pc1_t[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-pc2_t[i]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] x, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s, y;
        logic [5:0] b;
        for (int i = 0; i < 48; i++) e[47-i] = x[32-e_t[i]];
        e = e ^ k;
        for (int j = 0; j < 8; j++) begin
            b = e[47-6*j -: 6];
            s[31-4*j -: 4] = sbox[j*64 + int'({b[5], b[0], b[4:1]})];
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-p_t[i]];
        return y;
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] n);
        return n == 2'd0 ? x : n == 2'd1 ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] n);
        return n == 2'd1 ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    typedef enum logic [1:0] {idle, run, done} state_t;
    state_t state;
    logic [3:0] rnd;
    logic [31:0] l, r, fr;
    logic [27:0] c, d, cn, dn;
    logic [1:0] rot;
    logic one, dec;

`ifndef DES_DUAL_MODE_EN
    assign dec = 1'b1;
`endif
    assign in_ready = state == idle;
    assign busy = state != idle;

    always_comb begin
        one = rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15;
        rot = dec ? (rnd == 4'd0 ? 2'd0 : one ? 2'd1 : 2'd2) : (rnd == 4'd0 || one ? 2'd1 : 2'd2);
        cn = dec ? rotr(c, rot) : rotl(c, rot);
        dn = dec ? rotr(d, rot) : rotl(d, rot);
        fr = feistel(r, pc2({cn, dn}));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= idle;
            rnd <= '0;
            out_valid <= 1'b0;
            plain <= '0;
        end else begin
            case (state)
                idle: if (in_valid) begin
                    {l, r} <= ip(cipher);
                    {c, d} <= pc1(key);
                    rnd <= '0;
`ifdef DES_DUAL_MODE_EN
                    dec <= mode;
`endif
                    state <= run;
                end
                run: begin
                    l <= r;
                    r <= l ^ fr;
                    c <= cn;
                    d <= dn;
                    rnd <= rnd + 4'd1;
                    // last round leaves the halves unswapped before the final permutation
                    if (rnd == 4'd15) begin
                        plain <= fp({l ^ fr, r});
                        out_valid <= 1'b1;
                        state <= done;
                    end
                end
                done: if (out_ready) begin
                    out_valid <= 1'b0;
                    state <= idle;
                end
                default: state <= idle;
            endcase
        end
    end
endmodule

// File: tb/tb_des_decrypt_iter.sv
// tb_des_decrypt_iter: scoreboard bench for des_decrypt_iter using DES known-answer vectors.
module tb_des_decrypt_iter;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [63:0] cipher = '0, key = '0;
    logic in_ready, out_valid, busy;
    logic [63:0] plain;
`ifdef DES_DUAL_MODE_EN
    logic mode = 1'b1;
`endif

    des_decrypt_iter dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cipher(cipher), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .plain(plain), .busy(busy)
`ifdef DES_DUAL_MODE_EN
        , .mode(mode)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [63:0] v; bit ck;} exp_t;
    exp_t exp_q[$];
    exp_t e;
    int acc_q[$];
    int n_cmp = 0, n_err = 0, ncyc = 0, last_acc = -1;
    bit b2b = 1'b0, ov_prev = 1'b0;
    logic [63:0] last_plain = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // monitor: accept timing, output latency and scoreboard pops
    always @(negedge clk) begin
        ncyc++;
        if (reset) begin
            acc_q.delete();
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                if (b2b && last_acc >= 0) chk("accept_spacing", 64'(ncyc - last_acc), 64'd18);
                last_acc = ncyc;
                acc_q.push_back(ncyc);
            end
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) chk("spurious_out_valid", {63'd0, out_valid}, 64'd0);
                else chk("latency", 64'(ncyc - acc_q.pop_front()), 64'd17);
            end
            ov_prev = out_valid;
            if (out_valid && out_ready) begin
                last_plain = plain;
                if (exp_q.size() == 0) chk("unexpected_output", {63'd0, out_valid}, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    if (e.ck) chk("plain", plain, e.v);
                end
            end
        end
    end

    task automatic send(input logic [63:0] k, input logic [63:0] c, input logic [63:0] x, input bit keep, input bit ck);
        bit got = 1'b0;
        if (keep) exp_q.push_back('{x, ck});
        key = k;
        cipher = c;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        key = ~k;
        cipher = ~c;
        if (!got) begin
            chk("accept_timeout", {63'd0, in_ready}, 64'd1);
            if (keep) void'(exp_q.pop_back());
        end
    endtask

    task automatic drain();
        int i = 0;
        while (i < 200 && !(exp_q.size() == 0 && in_ready)) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (i == 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_plain", plain, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b0;

        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1, 1);
        drain();
        send(64'h0101010101010101, 64'h8CA64DE9C1B123A7, 64'h0, 1, 1);
        send(64'h0000000000000000, 64'h8CA64DE9C1B123A7, 64'h0, 1, 1);
        send(64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 1, 1);
        send(64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF, 1, 1);
        drain();

        out_ready = 1'b0;
        send(64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 64'h4E6F772069732074, 1, 1);
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        cipher = 64'h8CA64DE9C1B123A7;
        key = '0;
        for (int i = 0; i < 10; i++) begin
            chk("hold_plain", plain, 64'h4E6F772069732074);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_done", {63'd0, in_ready}, 64'd1);
        chk("busy_after_done", {63'd0, busy}, 64'd0);

        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0, 0, 0);
        repeat (7) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("in_ready_after_abort", {63'd0, in_ready}, 64'd1);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bad |= out_valid;
            @(posedge clk);
            #1;
        end
        chk("no_out_valid_after_abort", {63'd0, bad}, 64'd0);
        send(64'hECCBA8866443200E, 64'h7A17ECABF0F54BFA, 64'hFEDCBA9876543210, 1, 1);
        drain();

        b2b = 1'b1;
        last_acc = -1;
        send(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF, 1, 1);
        send(64'h0E329232EA6D0D73, 64'h0000000000000000, 64'h8787878787878787, 1, 1);
        send(64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF, 1, 1);
        send(64'h0123456789ABCDEF, 64'h3FA40E8A984D4815, 64'h4E6F772069732074, 1, 1);
        drain();
        b2b = 1'b0;

`ifdef DES_DUAL_MODE_EN
        mode = 1'b0;
        send(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 64'h85E813540F0AB405, 1, 1);
        drain();
        for (int i = 0; i < 16; i++) begin
            logic [63:0] p, k;
            p = {$urandom, $urandom};
            k = {$urandom, $urandom};
            mode = 1'b0;
            send(k, p, 64'h0, 1, 0);
            drain();
            mode = 1'b1;
            send(k, last_plain, p, 1, 1);
            drain();
        end
`endif
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
